mips_muldiv_unit: RTL and testbench
===================================

Name: mips_muldiv_unit

Overview:
- Iterative multiply/divide unit with architectural HI/LO registers for the pipelined MIPS core.
- Adds MULT, MULTU, DIV, DIVU, MTHI and MTLO; MFHI and MFLO read the HI/LO outputs directly.
- Sits beside the EX-stage ALU. The hazard detection unit uses `busy` to stall IF/ID/PC while an operation runs.
- Parametrised successor to the fixed 32-bit single-cycle ALU path.

Parameters:
- DATA_WIDTH, 32: operand, HI and LO width; must be even and at least 4.
- FAST_MULT, 0: 1 = MULT/MULTU finish in a single iteration using a combinational multiplier; 0 = shift-add over DATA_WIDTH iterations.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  issue request, sampled on the rising edge of clk.
- op  in  3  operation: 000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO, 110/111 NOP.
- A  in  DATA_WIDTH  rs operand: multiplicand, dividend, or MTHI/MTLO data.
- B  in  DATA_WIDTH  rt operand: multiplier or divisor.
- busy  out  1  high whenever state is not IDLE.
- done  out  1  one-cycle pulse when HI/LO have just been updated by a mult/div.
- div_by_zero  out  1  pulse coincident with done for DIV/DIVU with B==0.
- HI  out  DATA_WIDTH  HI register.
- LO  out  DATA_WIDTH  LO register.

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE, HI=0, LO=0, done=0, div_by_zero=0, iteration counter=0, internal operands cleared. Reset mid-operation aborts the operation; no partial result reaches HI/LO.
- FSM states:
  - IDLE: on start with op in {MULT,MULTU,DIV,DIVU}, latch operands as magnitudes (signed ops take absolute value and record sign of A and sign of B), load counter=DATA_WIDTH, go to RUN.
    - On start with op=MTHI: HI<=A at that edge, stay IDLE, no done.
    - On start with op=MTLO: LO<=A at that edge, stay IDLE, no done.
    - On start with NOP: no effect.
  - RUN: one iteration per cycle, counter decrements.
    - Multiply: shift-add into a 2*DATA_WIDTH product register.
    - Divide: restoring, one quotient bit per cycle.
    - When the counter reaches 1, next state is FIX.
    - FAST_MULT=1: multiplies load counter=1, so RUN lasts exactly one cycle.
  - FIX: apply sign correction and write HI/LO, assert done (and div_by_zero if applicable) for exactly the following cycle, return to IDLE.
- Latency:
  - Start sampled at edge E0; HI/LO valid and done=1 after edge E0+DATA_WIDTH+1.
  - With FAST_MULT=1, multiplies complete after E0+2.
  - busy is high from after E0 until the edge that raises done; busy=0 whenever done=1.
- Back-to-back: a start asserted in the same cycle as done is accepted.
- start while busy=1 is ignored entirely, including MTHI/MTLO. The pipeline must hold the instruction stalled.
- Operands A/B are sampled only at E0; later changes have no effect.
- Arithmetic rules:
  - MULT: signed 2*DATA_WIDTH product; HI=upper half, LO=lower half. MULTU: unsigned.
  - DIV: signed. LO=quotient truncated toward zero; HI=remainder, which takes the sign of A. DIVU: unsigned.
  - Signed overflow, most-negative / -1: LO=most-negative value, HI=0, no flag.
- Divide by zero (DIV or DIVU with B==0): runs the full latency; HI=A unchanged, LO=all ones; div_by_zero pulses with done.
- The HI/LO outputs always show the last committed values; intermediate iterations never appear on them.

Test Plan:
- Reset low mid-RUN of DIVU 100/7 at E0+10 -> busy=0, HI=0, LO=0 immediately; no done pulse; after release, MTLO 0x1234 -> LO=0x00001234 next edge.
- MULTU A=0xFFFFFFFF, B=0xFFFFFFFF -> after E0+33: HI=0xFFFFFFFE, LO=0x00000001, done one cycle, busy high for cycles 1..32.
- MULT A=0xFFFFFFFD (-3), B=7 -> HI=0xFFFFFFFF, LO=0xFFFFFFEB; FAST_MULT=1 build gives the same values with done after E0+2.
- DIV A=0xFFFFFFF9 (-7), B=2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF. DIV 0x80000000/0xFFFFFFFF -> LO=0x80000000, HI=0.
- DIVU A=100, B=0 -> LO=0xFFFFFFFF, HI=0x00000064, div_by_zero and done both pulse for one cycle.
- Stall rules:
  - Start MULTU 3*5, then MTHI 0xAAAA while busy -> ignored; final HI=0, LO=15.
  - New start on the done cycle -> accepted, busy stays low exactly one cycle.

Source files
------------

// File: rtl/mips_muldiv_unit.sv
// mips_muldiv_unit
// Iterative multiply/divide unit with the architectural HI/LO registers.
// It sits beside the EX-stage ALU. The hazard unit stalls IF/ID/PC while busy is high.
//
// Ports
//   clk          rising-edge clock
//   reset        asynchronous active-low reset
//   start        issue request, sampled on the rising edge
//   op[2:0]      000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO,
//                110/111 NOP
//   A, B         rs / rt operands, sampled only on the accepting edge
//   busy         high while the unit is not idle
//   done         one-cycle pulse after HI/LO were written by a mult/div
//   div_by_zero  pulse coincident with done for DIV/DIVU with B==0
//   HI, LO       architectural HI/LO registers
//
// Operands are held as magnitudes plus recorded signs. Each multiply or
// divide iteration works on unsigned values. The sign fix-up is applied
// once, in FIX, when HI/LO are committed.
module mips_muldiv_unit #(
  parameter int DATA_WIDTH = 32,
  parameter bit FAST_MULT  = 1'b0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [2:0]            op,
  input  logic [DATA_WIDTH-1:0] A,
  input  logic [DATA_WIDTH-1:0] B,
  output logic                  busy,
  output logic                  done,
  output logic                  div_by_zero,
  output logic [DATA_WIDTH-1:0] HI,
  output logic [DATA_WIDTH-1:0] LO
);

  localparam int W  = DATA_WIDTH;
  localparam int CW = $clog2(W + 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_FIX  = 2'd2
  } state_e;

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [2*W-1:0]  acc_q, acc_d;    // mult: {partial, multiplier}; div: {rem, quotient}
  logic [W-1:0]    opa_q, opa_d;    // |A|
  logic [W-1:0]    opb_q, opb_d;    // |B|
  logic            is_div_q, is_div_d;
  logic            sa_q, sa_d;
  logic            sb_q, sb_d;
  logic [W-1:0]    hi_q, hi_d;
  logic [W-1:0]    lo_q, lo_d;
  logic            done_q, done_d;
  logic            dz_q, dz_d;

  // Operand conditioning: unsigned ops (op[0]=1) never record a sign.
  logic            a_neg_s, b_neg_s;
  logic [W-1:0]    a_mag_s, b_mag_s;
  assign a_neg_s = ~op[0] & A[W-1];
  assign b_neg_s = ~op[0] & B[W-1];
  assign a_mag_s = a_neg_s ? (-A) : A;
  assign b_mag_s = b_neg_s ? (-B) : B;

  // Shift-add step: add the multiplicand when the multiplier LSB is set, then shift right.
  logic [W:0]      mul_sum_s;
  logic [2*W-1:0]  mul_next_s;
  assign mul_sum_s  = {1'b0, acc_q[2*W-1:W]} + (acc_q[0] ? {1'b0, opa_q} : {(W+1){1'b0}});
  assign mul_next_s = {mul_sum_s, acc_q[W-1:1]};

  logic [2*W-1:0]  fast_prod_s;
  assign fast_prod_s = {{W{1'b0}}, opa_q} * {{W{1'b0}}, opb_q};

  // Restoring-divide step. rem < divisor, so the shifted remainder fits W+1 bits
  // and the top bit of the difference is a reliable borrow.
  logic [W:0]      div_shift_s, div_diff_s;
  logic            div_ge_s;
  logic [W-1:0]    div_rem_s;
  logic [2*W-1:0]  div_next_s;
  assign div_shift_s = {acc_q[2*W-1:W], acc_q[W-1]};
  assign div_diff_s  = div_shift_s - {1'b0, opb_q};
  assign div_ge_s    = ~div_diff_s[W];
  assign div_rem_s   = div_ge_s ? div_diff_s[W-1:0] : div_shift_s[W-1:0];
  assign div_next_s  = {div_rem_s, acc_q[W-2:0], div_ge_s};

  // Sign fix-up. The most-negative/-1 case produces the most-negative quotient with no extra logic.
  logic [2*W-1:0]  prod_fix_s;
  logic [W-1:0]    quo_fix_s, rem_fix_s, a_orig_s;
  logic            div_zero_s;
  assign prod_fix_s = (sa_q ^ sb_q) ? (-acc_q) : acc_q;
  assign quo_fix_s  = (sa_q ^ sb_q) ? (-acc_q[W-1:0]) : acc_q[W-1:0];
  assign rem_fix_s  = sa_q ? (-acc_q[2*W-1:W]) : acc_q[2*W-1:W];
  assign a_orig_s   = sa_q ? (-opa_q) : opa_q;
  assign div_zero_s = (opb_q == {W{1'b0}});

  // Next-state, datapath and HI/LO update logic.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    opa_d    = opa_q;
    opb_d    = opb_q;
    is_div_d = is_div_q;
    sa_d     = sa_q;
    sb_d     = sb_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    done_d   = 1'b0;
    dz_d     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          case (op)
            3'b000, 3'b001, 3'b010, 3'b011: begin
              is_div_d = op[1];
              sa_d     = a_neg_s;
              sb_d     = b_neg_s;
              opa_d    = a_mag_s;
              opb_d    = b_mag_s;
              acc_d    = op[1] ? {{W{1'b0}}, a_mag_s} : {{W{1'b0}}, b_mag_s};
              cnt_d    = (FAST_MULT && !op[1]) ? CW'(1) : CW'(W);
              state_d  = S_RUN;
            end
            3'b100:  hi_d = A;
            3'b101:  lo_d = A;
            default: begin end
          endcase
        end else begin
          state_d = S_IDLE;
        end
      end
      S_RUN: begin
        cnt_d = cnt_q - CW'(1);
        if (is_div_q) begin
          acc_d = div_next_s;
        end else if (FAST_MULT) begin
          acc_d = fast_prod_s;
        end else begin
          acc_d = mul_next_s;
        end
        if (cnt_q == CW'(1)) begin
          state_d = S_FIX;
        end else begin
          state_d = S_RUN;
        end
      end
      S_FIX: begin
        state_d = S_IDLE;
        done_d  = 1'b1;
        if (!is_div_q) begin
          hi_d = prod_fix_s[2*W-1:W];
          lo_d = prod_fix_s[W-1:0];
        end else if (div_zero_s) begin
          hi_d = a_orig_s;
          lo_d = {W{1'b1}};
          dz_d = 1'b1;
        end else begin
          hi_d = rem_fix_s;
          lo_d = quo_fix_s;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers. Reset aborts any operation in flight.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= S_IDLE;
      cnt_q    <= {CW{1'b0}};
      acc_q    <= {(2*W){1'b0}};
      opa_q    <= {W{1'b0}};
      opb_q    <= {W{1'b0}};
      is_div_q <= 1'b0;
      sa_q     <= 1'b0;
      sb_q     <= 1'b0;
      hi_q     <= {W{1'b0}};
      lo_q     <= {W{1'b0}};
      done_q   <= 1'b0;
      dz_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      opa_q    <= opa_d;
      opb_q    <= opb_d;
      is_div_q <= is_div_d;
      sa_q     <= sa_d;
      sb_q     <= sb_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      done_q   <= done_d;
      dz_q     <= dz_d;
    end
  end

  assign busy        = (state_q != S_IDLE);
  assign done        = done_q;
  assign div_by_zero = dz_q;
  assign HI          = hi_q;
  assign LO          = lo_q;

endmodule

// File: tb/tb_mips_muldiv_unit.sv
// Self-checking bench for mips_muldiv_unit.
// It uses a shift-add build (dut) and a FAST_MULT build (dut_f).
// The two builds share op/A/B but have separate start lines.
module tb_mips_muldiv_unit;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         reset, start, start_f;
  logic [2:0]   op;
  logic [W-1:0] A, B;
  logic         busy, done, div_by_zero;
  logic [W-1:0] HI, LO;
  logic         busy_f, done_f, dz_f;
  logic [W-1:0] hi_f, lo_f;

  int n_total = 0;
  int n_pass  = 0;

  logic [W-1:0] exp_hi = 32'h0, exp_lo = 32'h0;
  logic [W-1:0] exp_hi_f = 32'h0, exp_lo_f = 32'h0;

  mips_muldiv_unit #(.DATA_WIDTH(W), .FAST_MULT(1'b0)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .A(A), .B(B),
    .busy(busy), .done(done), .div_by_zero(div_by_zero), .HI(HI), .LO(LO)
  );

  mips_muldiv_unit #(.DATA_WIDTH(W), .FAST_MULT(1'b1)) dut_f (
    .clk(clk), .reset(reset), .start(start_f), .op(op), .A(A), .B(B),
    .busy(busy_f), .done(done_f), .div_by_zero(dz_f), .HI(hi_f), .LO(lo_f)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string nm, input logic [63:0] got, input logic [63:0] expv);
    n_total++;
    if (got === expv) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, got, expv);
    end
  endtask

  // Reference model built from the architectural arithmetic rules
  function automatic void ref_model(input logic [2:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                                    output logic [W-1:0] hi, output logic [W-1:0] lo, output logic dz);
    int          ai, bi;
    longint      p;
    logic [63:0] pu;
    ai = a;
    bi = b;
    dz = 1'b0;
    hi = 32'h0;
    lo = 32'h0;
    case (o)
      3'd0: begin p = longint'(ai) * longint'(bi); hi = p[63:32]; lo = p[31:0]; end
      3'd1: begin pu = {32'h0, a} * {32'h0, b}; hi = pu[63:32]; lo = pu[31:0]; end
      3'd2: begin
        if (b == 32'h0) begin hi = a; lo = 32'hFFFF_FFFF; dz = 1'b1; end
        else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin hi = 32'h0; lo = 32'h8000_0000; end
        else begin lo = ai / bi; hi = ai % bi; end
      end
      3'd3: begin
        if (b == 32'h0) begin hi = a; lo = 32'hFFFF_FFFF; dz = 1'b1; end
        else begin lo = a / b; hi = a % b; end
      end
      default: begin end
    endcase
  endfunction

  // Issue one mult/div and check it. The task returns at #1 after the done edge, so a follow-up call is back-to-back.
  task automatic run_op(input bit fast, input logic [2:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [W-1:0] ehi, input logic [W-1:0] elo, input logic edz,
                        input bit poke, input string nm);
    int   n;
    bit   ok, got_done;
    int   lat;
    logic [W-1:0] phi, plo;
    lat = fast ? 2 : W + 1;
    phi = fast ? exp_hi_f : exp_hi;
    plo = fast ? exp_lo_f : exp_lo;
    op = o; A = a; B = b;
    if (fast) start_f = 1'b1; else start = 1'b1;
    tick();
    start = 1'b0; start_f = 1'b0;
    op = 3'($urandom); A = $urandom; B = $urandom;
    n = 0; ok = 1'b1; got_done = 1'b0;
    while (n < 60 && !got_done) begin
      if ((fast ? busy_f : busy) !== 1'b1 || (fast ? done_f : done) !== 1'b0 ||
          (fast ? hi_f : HI) !== phi || (fast ? lo_f : LO) !== plo) ok = 1'b0;
      if (poke && n < 4) begin start = 1'b1; op = 3'b100; A = 32'h0000_AAAA; end
      else start = 1'b0;
      tick();
      n++;
      if ((fast ? done_f : done) === 1'b1) got_done = 1'b1;
    end
    start = 1'b0;
    check({nm, " latency"}, 64'(n), 64'(lat));
    check({nm, " busy/hold while running"}, {63'h0, ok}, 64'h1);
    check({nm, " busy at done"}, {63'h0, (fast ? busy_f : busy)}, 64'h0);
    check({nm, " done"}, {63'h0, (fast ? done_f : done)}, 64'h1);
    check({nm, " div_by_zero"}, {63'h0, (fast ? dz_f : div_by_zero)}, {63'h0, edz});
    check({nm, " HI"}, {32'h0, (fast ? hi_f : HI)}, {32'h0, ehi});
    check({nm, " LO"}, {32'h0, (fast ? lo_f : LO)}, {32'h0, elo});
    if (fast) begin exp_hi_f = ehi; exp_lo_f = elo; end
    else begin exp_hi = ehi; exp_lo = elo; end
  endtask

  typedef struct {
    logic [2:0]   op;
    logic [W-1:0] a, b, hi, lo;
    logic         dz;
  } vec_t;

  vec_t vecs[10];

  initial begin
    logic [W-1:0] rh, rl, ra, rb;
    logic         rdz;
    logic [2:0]   ro;
    bit           ok;

    vecs[0] = '{3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0};
    vecs[1] = '{3'd0, 32'hFFFF_FFFD, 32'h0000_0007, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0};
    vecs[2] = '{3'd2, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0};
    vecs[3] = '{3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 1'b0};
    vecs[4] = '{3'd3, 32'h0000_0064, 32'h0000_0000, 32'h0000_0064, 32'hFFFF_FFFF, 1'b1};
    vecs[5] = '{3'd3, 32'h0000_0064, 32'h0000_0007, 32'h0000_0002, 32'h0000_000E, 1'b0};
    vecs[6] = '{3'd1, 32'h0000_0003, 32'h0000_0005, 32'h0000_0000, 32'h0000_000F, 1'b0};
    vecs[7] = '{3'd2, 32'h0000_0007, 32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD, 1'b0};
    vecs[8] = '{3'd2, 32'hFFFF_FFF9, 32'h0000_0000, 32'hFFFF_FFF9, 32'hFFFF_FFFF, 1'b1};
    vecs[9] = '{3'd0, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000, 1'b0};

    reset = 1'b0; start = 1'b0; start_f = 1'b0; op = 3'd0; A = 32'h0; B = 32'h0;
    tick(); tick();
    check("reset busy", {63'h0, busy}, 64'h0);
    check("reset done", {63'h0, done}, 64'h0);
    check("reset dz", {63'h0, div_by_zero}, 64'h0);
    check("reset HI", {32'h0, HI}, 64'h0);
    check("reset LO", {32'h0, LO}, 64'h0);
    reset = 1'b1;
    tick();

    // Directed table. Consecutive entries start on the done cycle of the previous one.
    for (int i = 0; i < 10; i++)
      run_op(1'b0, vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].hi, vecs[i].lo, vecs[i].dz, 1'b0, $sformatf("vec%0d", i));
    for (int i = 0; i < 10; i++)
      if (vecs[i].op[2:1] == 2'b00)
        run_op(1'b1, vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].hi, vecs[i].lo, vecs[i].dz, 1'b0, $sformatf("fast vec%0d", i));

    // MTHI driven while busy must be ignored
    run_op(1'b0, 3'd1, 32'd3, 32'd5, 32'h0, 32'd15, 1'b0, 1'b1, "stall mthi");
    tick();
    check("done one cycle", {63'h0, done}, 64'h0);
    check("dz low after op", {63'h0, div_by_zero}, 64'h0);

    // Randomized mix checked against the reference model
    for (int i = 0; i < 40; i++) begin
      ro = 3'($urandom_range(0, 5));
      ra = $urandom;
      case ($urandom_range(0, 7))
        0: rb = 32'h0;
        1: rb = 32'($urandom_range(1, 9));
        2: rb = 32'hFFFF_FFFF;
        default: rb = $urandom;
      endcase
      if (ro >= 3'd4) begin
        op = ro; A = ra; start = 1'b1;
        tick();
        start = 1'b0;
        if (ro == 3'd4) exp_hi = ra; else exp_lo = ra;
        check($sformatf("rnd%0d move HI", i), {32'h0, HI}, {32'h0, exp_hi});
        check($sformatf("rnd%0d move LO", i), {32'h0, LO}, {32'h0, exp_lo});
        check($sformatf("rnd%0d move no done", i), {62'h0, busy, done}, 64'h0);
      end else begin
        ref_model(ro, ra, rb, rh, rl, rdz);
        run_op(1'b0, ro, ra, rb, rh, rl, rdz, 1'b0, $sformatf("rnd%0d", i));
      end
    end
    for (int i = 0; i < 10; i++) begin
      ro = 3'($urandom_range(0, 1));
      ra = $urandom; rb = $urandom;
      ref_model(ro, ra, rb, rh, rl, rdz);
      run_op(1'b1, ro, ra, rb, rh, rl, rdz, 1'b0, $sformatf("fast rnd%0d", i));
    end

    // Reset during RUN: abort with no done pulse, then MTLO works
    run_op(1'b0, 3'd1, 32'd3, 32'd5, 32'h0, 32'd15, 1'b0, 1'b0, "pre-reset");
    op = 3'd3; A = 32'd100; B = 32'd7; start = 1'b1;
    tick();
    start = 1'b0;
    repeat (10) tick();
    check("mid-run busy", {63'h0, busy}, 64'h1);
    reset = 1'b0;
    #1;
    check("abort busy", {63'h0, busy}, 64'h0);
    check("abort HI", {32'h0, HI}, 64'h0);
    check("abort LO", {32'h0, LO}, 64'h0);
    exp_hi = 32'h0; exp_lo = 32'h0;
    ok = 1'b1;
    tick();
    if (done !== 1'b0) ok = 1'b0;
    tick();
    reset = 1'b1;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (done !== 1'b0 || busy !== 1'b0 || LO !== 32'h0) ok = 1'b0;
    end
    check("no done after abort", {63'h0, ok}, 64'h1);
    op = 3'd5; A = 32'h0000_1234; start = 1'b1;
    tick();
    start = 1'b0;
    check("mtlo after reset LO", {32'h0, LO}, 64'h0000_1234);
    check("mtlo after reset HI", {32'h0, HI}, 64'h0);
    check("mtlo no done", {63'h0, done}, 64'h0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
